// File: rtl/block_ram_arbiter.sv
// block_ram_arbiter
//   Two-requester arbiter in front of a single block_ram (one registered read
//   port, one write port). Reads and writes are arbitrated independently with
//   their own round-robin priority bits, so one read and one write may be
//   granted in the same cycle. Read data returns to the winning port on a
//   one-cycle response strobe, exactly one cycle after acceptance.
//
// Ports
//   CLK, reset            system clock, synchronous active-high reset
//   reqN_valid/ready      request handshake for port N (N = 0, 1)
//   reqN_we               1 = write, 0 = read
//   reqN_addr/wdata       request word address / write data
//   rspN_valid/rdata      read response pulse and data for port N
//   raddr, rdata          block_ram read port (rdata valid one cycle after raddr)
//   waddr, wdata, wren    block_ram write port
//
// Configuration
//   BLOCK_RAM_ARBITER_RAW_BYPASS_EN
//     defined   : same-address read/write collision grants both; the read
//                 returns the write data (write-first).
//     undefined : on a collision the read is stalled one cycle and the write
//                 proceeds; the read priority is left untouched by the stall.
module block_ram_arbiter #(
  parameter int unsigned addr_bits = 11,
  parameter int unsigned data_bits = 8,
  parameter int unsigned depth     = 1152
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_we,
  input  logic [addr_bits-1:0] req0_addr,
  input  logic [data_bits-1:0] req0_wdata,
  output logic                 rsp0_valid,
  output logic [data_bits-1:0] rsp0_rdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_we,
  input  logic [addr_bits-1:0] req1_addr,
  input  logic [data_bits-1:0] req1_wdata,
  output logic                 rsp1_valid,
  output logic [data_bits-1:0] rsp1_rdata,
  output logic [addr_bits-1:0] raddr,
  input  logic [data_bits-1:0] rdata,
  output logic [addr_bits-1:0] waddr,
  output logic [data_bits-1:0] wdata,
  output logic                 wren
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  function automatic logic in_range(input logic [addr_bits-1:0] a);
    return 32'(a) < depth;
  endfunction

  // Priority and response tag state
  port_t                rd_prio;
  port_t                wr_prio;
  port_t                rsp_owner;
  logic                 rsp_pending;
  logic                 rsp_zero;
  logic [addr_bits-1:0] raddr_q;

  // Arbitration signals
  logic                 rd_req0, rd_req1;
  logic                 wr_req0, wr_req1;
  logic                 rd_pick;
  port_t                rd_win;
  logic                 rd_gnt;
  logic                 wr_gnt;
  port_t                wr_win;
  logic [addr_bits-1:0] rd_addr_sel;
  logic [addr_bits-1:0] wr_addr_sel;
  logic [data_bits-1:0] wr_data_sel;
  logic                 collide;
  logic [data_bits-1:0] rsp_data;

  always_comb begin
    rd_req0 = req0_valid & ~req0_we & ~reset;
    rd_req1 = req1_valid & ~req1_we & ~reset;
    wr_req0 = req0_valid &  req0_we & ~reset;
    wr_req1 = req1_valid &  req1_we & ~reset;

    // Write arbiter
    wr_gnt = wr_req0 | wr_req1;
    if (wr_req0 && wr_req1) begin
      wr_win = wr_prio;
    end else if (wr_req1) begin
      wr_win = PORT1;
    end else begin
      wr_win = PORT0;
    end

    // Read arbiter (candidate before collision handling)
    rd_pick = rd_req0 | rd_req1;
    if (rd_req0 && rd_req1) begin
      rd_win = rd_prio;
    end else if (rd_req1) begin
      rd_win = PORT1;
    end else begin
      rd_win = PORT0;
    end

    wr_addr_sel = (wr_win == PORT1) ? req1_addr  : req0_addr;
    wr_data_sel = (wr_win == PORT1) ? req1_wdata : req0_wdata;
    rd_addr_sel = (rd_win == PORT1) ? req1_addr  : req0_addr;

    collide = wr_gnt & rd_pick & (rd_addr_sel == wr_addr_sel) & in_range(rd_addr_sel);

`ifdef BLOCK_RAM_ARBITER_RAW_BYPASS_EN
    rd_gnt = rd_pick;
`else
    rd_gnt = rd_pick & ~collide;
`endif

    // A port carries either a read or a write, never both, so OR is safe.
    req0_ready = (rd_gnt & (rd_win == PORT0)) | (wr_gnt & (wr_win == PORT0));
    req1_ready = (rd_gnt & (rd_win == PORT1)) | (wr_gnt & (wr_win == PORT1));

    wren  = wr_gnt & in_range(wr_addr_sel);
    waddr = wr_addr_sel;
    wdata = wr_data_sel;

    // raddr follows the winner combinationally and otherwise holds its last value
    raddr = rd_gnt ? rd_addr_sel : raddr_q;
  end

  // Read address holding register; deliberately not reset so raddr simply
  // keeps whatever was last presented to the RAM.
  always_ff @(posedge CLK) begin
    if (rd_gnt) begin
      raddr_q <= rd_addr_sel;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      rd_prio     <= PORT0;
      wr_prio     <= PORT0;
      rsp_owner   <= PORT0;
      rsp_pending <= 1'b0;
      rsp_zero    <= 1'b0;
    end else begin
      if (rd_gnt) begin
        rd_prio   <= (rd_win == PORT0) ? PORT1 : PORT0;
        rsp_owner <= rd_win;
        rsp_zero  <= ~in_range(rd_addr_sel);
      end
      if (wr_gnt) begin
        wr_prio <= (wr_win == PORT0) ? PORT1 : PORT0;
      end
      rsp_pending <= rd_gnt;
    end
  end

`ifdef BLOCK_RAM_ARBITER_RAW_BYPASS_EN
  logic                 rsp_bypass;
  logic [data_bits-1:0] bypass_data;

  always_ff @(posedge CLK) begin
    if (reset) begin
      rsp_bypass  <= 1'b0;
      bypass_data <= '0;
    end else if (rd_gnt) begin
      rsp_bypass  <= collide;
      bypass_data <= wr_data_sel;
    end
  end
`endif

  // Response path: rdata arrives in the cycle after acceptance, so the data
  // mux is combinational on the registered tag. Reset suppresses a response
  // already in flight.
  always_comb begin
    rsp_data = rdata;
`ifdef BLOCK_RAM_ARBITER_RAW_BYPASS_EN
    if (rsp_bypass) begin
      rsp_data = bypass_data;
    end
`endif
    if (rsp_zero) begin
      rsp_data = '0;
    end
    rsp0_valid = rsp_pending & ~reset & (rsp_owner == PORT0);
    rsp1_valid = rsp_pending & ~reset & (rsp_owner == PORT1);
    rsp0_rdata = rsp0_valid ? rsp_data : '0;
    rsp1_rdata = rsp1_valid ? rsp_data : '0;
  end

endmodule

// File: tb/tb_block_ram_arbiter.sv
// Testbench for block_ram_arbiter: directed test-plan steps followed by
// randomized traffic, all checked against a behavioural model of the
// arbitration rules and a shadow memory. A behavioural block_ram is attached.
module tb_block_ram_arbiter;

  localparam int DEPTH = 1152;

  logic        CLK = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_we;
  logic [10:0] req0_addr;
  logic [7:0]  req0_wdata;
  logic        rsp0_valid;
  logic [7:0]  rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [10:0] req1_addr;
  logic [7:0]  req1_wdata;
  logic        rsp1_valid;
  logic [7:0]  rsp1_rdata;
  logic [10:0] raddr;
  logic [7:0]  rdata;
  logic [10:0] waddr;
  logic [7:0]  wdata;
  logic        wren;

  always #5 CLK = ~CLK;

  block_ram_arbiter #(
    .addr_bits(11),
    .data_bits(8),
    .depth(DEPTH)
  ) dut (
    .CLK(CLK), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .raddr(raddr), .rdata(rdata),
    .waddr(waddr), .wdata(wdata), .wren(wren)
  );

  // Behavioural block_ram: registered read, read-old on same-address write.
  // Out-of-range reads return a non-zero pattern so zero-forcing is observable.
  logic [7:0] ram [0:DEPTH-1];
  logic [7:0] ram_q = 8'h00;
  always @(posedge CLK) begin
    if (int'(raddr) < DEPTH) ram_q <= ram[raddr];
    else ram_q <= 8'hA5;
    if (wren && int'(waddr) < DEPTH) ram[waddr] <= wdata;
  end
  assign rdata = ram_q;

  // Reference model state
  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [7:0]  ref_mem [0:DEPTH-1];
  int          rd_pref = 0;
  int          wr_pref = 0;
  bit          pend = 1'b0;
  int          pend_port = 0;
  logic [7:0]  pend_data = 8'h00;
  bit          raddr_known = 1'b0;
  int          raddr_exp = 0;

  // Observations from the most recent cycle, for test-plan checks
  bit          last_rdy [2];
  bit          obs_rsp_valid [2];
  logic [7:0]  obs_rsp_data [2];
  bit          obs_wren;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v0, input bit w0, input int a0, input logic [7:0] d0,
                       input bit v1, input bit w1, input int a1, input logic [7:0] d1);
    req0_valid = v0; req0_we = w0; req0_addr = 11'(a0); req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = 11'(a1); req1_wdata = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0, 8'h00);
  endtask

  // One clock cycle: predict from the rules, check at the falling edge,
  // then advance the model across the rising edge.
  task automatic cycle();
    bit         v [2];
    bit         w [2];
    int         a [2];
    logic [7:0] d [2];
    int         rlist [$];
    int         wlist [$];
    int         rd_win;
    int         wr_win;
    bit         coll;
    bit         exp_wren;

    v[0] = req0_valid; w[0] = req0_we; a[0] = int'(req0_addr); d[0] = req0_wdata;
    v[1] = req1_valid; w[1] = req1_we; a[1] = int'(req1_addr); d[1] = req1_wdata;
    rd_win = -1;
    wr_win = -1;
    coll   = 1'b0;
    if (!reset) begin
      for (int p = 0; p < 2; p++) begin
        if (v[p]) begin
          if (w[p]) wlist.push_back(p);
          else rlist.push_back(p);
        end
      end
      if (wlist.size() == 1) wr_win = wlist[0];
      else if (wlist.size() == 2) wr_win = wr_pref;
      if (rlist.size() == 1) rd_win = rlist[0];
      else if (rlist.size() == 2) rd_win = rd_pref;
      if (rd_win >= 0 && wr_win >= 0 && a[rd_win] == a[wr_win] && a[rd_win] < DEPTH) begin
        coll = 1'b1;
`ifndef BLOCK_RAM_ARBITER_RAW_BYPASS_EN
        rd_win = -1;
`endif
      end
    end
    exp_wren = (wr_win >= 0) && (a[wr_win] < DEPTH);

    @(negedge CLK);
    check("rsp0_valid", 32'(rsp0_valid), 32'(pend && pend_port == 0 && !reset));
    check("rsp1_valid", 32'(rsp1_valid), 32'(pend && pend_port == 1 && !reset));
    if (pend && !reset) begin
      if (pend_port == 0) check("rsp0_rdata", 32'(rsp0_rdata), 32'(pend_data));
      else check("rsp1_rdata", 32'(rsp1_rdata), 32'(pend_data));
    end
    check("req0_ready", 32'(req0_ready), 32'(rd_win == 0 || wr_win == 0));
    check("req1_ready", 32'(req1_ready), 32'(rd_win == 1 || wr_win == 1));
    check("wren", 32'(wren), 32'(exp_wren));
    if (exp_wren) begin
      check("waddr", 32'(waddr), 32'(a[wr_win]));
      check("wdata", 32'(wdata), 32'(d[wr_win]));
    end
    if (rd_win >= 0) begin
      raddr_known = 1'b1;
      raddr_exp   = a[rd_win];
    end
    if (raddr_known) check("raddr", 32'(raddr), 32'(raddr_exp));

    last_rdy[0]      = req0_ready;
    last_rdy[1]      = req1_ready;
    obs_rsp_valid[0] = rsp0_valid;
    obs_rsp_valid[1] = rsp1_valid;
    obs_rsp_data[0]  = rsp0_rdata;
    obs_rsp_data[1]  = rsp1_rdata;
    obs_wren         = wren;

    if (reset) begin
      pend    = 1'b0;
      rd_pref = 0;
      wr_pref = 0;
    end else begin
      pend = (rd_win >= 0);
      if (rd_win >= 0) begin
        pend_port = rd_win;
        if (a[rd_win] >= DEPTH) pend_data = 8'h00;
        else if (coll) pend_data = d[wr_win];
        else pend_data = ref_mem[a[rd_win]];
        rd_pref = 1 - rd_win;
      end
      if (wr_win >= 0) begin
        if (a[wr_win] < DEPTH) ref_mem[a[wr_win]] = d[wr_win];
        wr_pref = 1 - wr_win;
      end
    end

    @(posedge CLK);
    #1;
  endtask

  function automatic int pick_addr();
    case ($urandom_range(0, 2))
      0:       return int'($urandom_range(0, 7));
      1:       return int'($urandom_range(DEPTH - 4, DEPTH + 3));
      default: return int'($urandom_range(0, 2047));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end

    // Reset: requests present but nothing may be accepted
    reset = 1'b1;
    drive(1'b1, 1'b1, 3, 8'h99, 1'b1, 1'b0, 4, 8'h00);
    cycle();
    cycle();
    check("tp_reset_ready0", 32'(last_rdy[0]), 32'd0);
    check("tp_reset_wren", 32'(obs_wren), 32'd0);
    reset = 1'b0;
    idle();
    cycle();

    // Single read by port 0
    drive(1'b1, 1'b1, 3, 8'h5A, 1'b0, 1'b0, 0, 8'h00);
    cycle();
    drive(1'b1, 1'b0, 3, 8'h00, 1'b0, 1'b0, 0, 8'h00);
    cycle();
    idle();
    cycle();
    check("tp_single_valid0", 32'(obs_rsp_valid[0]), 32'd1);
    check("tp_single_valid1", 32'(obs_rsp_valid[1]), 32'd0);
    check("tp_single_data", 32'(obs_rsp_data[0]), 32'h5A);

    // Port 1 read returns read priority to port 0
    drive(1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0, 3, 8'h00);
    cycle();
    idle();
    cycle();

    // Preload for contention and concurrency steps
    drive(1'b1, 1'b1, 10, 8'h11, 1'b0, 1'b0, 0, 8'h00); cycle();
    drive(1'b1, 1'b1, 11, 8'h22, 1'b0, 1'b0, 0, 8'h00); cycle();
    drive(1'b1, 1'b1, 21, 8'h33, 1'b0, 1'b0, 0, 8'h00); cycle();

    // Read contention: grants alternate 0,1,0,1
    drive(1'b1, 1'b0, 10, 8'h00, 1'b1, 1'b0, 11, 8'h00);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("tp_contention_grant0", 32'(last_rdy[0]), 32'((k % 2) == 0));
      if (k > 0)
        check("tp_contention_rsp", 32'(obs_rsp_data[(k - 1) % 2]),
              ((k - 1) % 2 == 0) ? 32'h11 : 32'h22);
    end
    idle();
    cycle();
    check("tp_contention_last", 32'(obs_rsp_data[1]), 32'h22);

    // Concurrent read and write
    drive(1'b1, 1'b1, 20, 8'h77, 1'b1, 1'b0, 21, 8'h00);
    cycle();
    check("tp_concurrent_rdy", 32'({last_rdy[0], last_rdy[1]}), 32'b11);
    idle();
    cycle();
    check("tp_concurrent_rsp1", 32'(obs_rsp_data[1]), 32'h33);
    drive(1'b1, 1'b0, 20, 8'h00, 1'b0, 1'b0, 0, 8'h00);
    cycle();
    idle();
    cycle();
    check("tp_concurrent_readback", 32'(obs_rsp_data[0]), 32'h77);

    // Same-address collision
    drive(1'b1, 1'b1, 5, 8'hC3, 1'b1, 1'b0, 5, 8'h00);
    cycle();
`ifdef BLOCK_RAM_ARBITER_RAW_BYPASS_EN
    check("tp_collision_rdy1", 32'(last_rdy[1]), 32'd1);
    idle();
    cycle();
`else
    check("tp_collision_rdy1_first", 32'(last_rdy[1]), 32'd0);
    drive(1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0, 5, 8'h00);
    cycle();
    check("tp_collision_rdy1_second", 32'(last_rdy[1]), 32'd1);
    idle();
    cycle();
`endif
    check("tp_collision_data", 32'(obs_rsp_data[1]), 32'hC3);

    // Out of range
    drive(1'b1, 1'b1, DEPTH, 8'hFF, 1'b0, 1'b0, 0, 8'h00);
    cycle();
    check("tp_oor_write_rdy", 32'(last_rdy[0]), 32'd1);
    check("tp_oor_write_wren", 32'(obs_wren), 32'd0);
    drive(1'b1, 1'b0, DEPTH, 8'h00, 1'b0, 1'b0, 0, 8'h00);
    cycle();
    idle();
    cycle();
    check("tp_oor_read_valid", 32'(obs_rsp_valid[0]), 32'd1);
    check("tp_oor_read_data", 32'(obs_rsp_data[0]), 32'h00);

    // Reset in the cycle after a read is accepted
    drive(1'b1, 1'b0, 3, 8'h00, 1'b0, 1'b0, 0, 8'h00);
    cycle();
    reset = 1'b1;
    idle();
    cycle();
    check("tp_reset_drop", 32'({obs_rsp_valid[0], obs_rsp_valid[1]}), 32'b00);
    reset = 1'b0;
    drive(1'b1, 1'b0, 10, 8'h00, 1'b1, 1'b0, 11, 8'h00);
    cycle();
    check("tp_reset_prio", 32'({last_rdy[0], last_rdy[1]}), 32'b10);
    idle();
    cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom()),
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom()));
      cycle();
    end
    reset = 1'b0;
    idle();
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
